can_frame_monitor: RTL

//  Passive CAN 2.0A/B frame decoder on the bus tap (canbus_tap_rx) that the CAN controller DUTs transmit on.
//  It recovers bit timing, removes stuff bits, checks CRC/form/stuff and reports each decoded frame as a one-cycle record.
//  It lets benches and on-chip loggers verify what a controller actually sent, independent of any receiving DUT.
//  It never drives the bus.

---
 rtl/can_frame_monitor.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/can_frame_monitor.sv
// Passive CAN 2.0A/B frame decoder: bit timing recovery, destuffing, CRC/form/stuff checks,
// one-cycle frame record or error pulse per frame. Never drives the bus.
module can_frame_monitor #(
  parameter int unsigned CLOCKS_PER_BIT = 40,
  parameter int unsigned SAMPLE_POINT   = 34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        frame_valid,
  output logic [28:0] frame_id,
  output logic        frame_ide,
  output logic        frame_rtr,
  output logic [3:0]  frame_dlc,
  output logic [63:0] frame_data,
  output logic        frame_acked,
  output logic        error_pulse,
  output logic [2:0]  error_code,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE_WAIT, S_IDLE, S_ARB, S_EXT, S_CTRL, S_DATA,
    S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF
  } state_t;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    crc_step = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
  endfunction

  logic       rx_s1, rx_s2, rx_prev;
  logic [9:0] cnt;
  logic       fall, sample;

  assign fall   = rx_prev & ~rx_s2;
  assign sample = (cnt == 10'(SAMPLE_POINT)) && !fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      cnt     <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (fall || cnt == 10'(CLOCKS_PER_BIT - 1)) cnt <= '0;
      else                                        cnt <= cnt + 10'd1;
    end
  end

  state_t      state, state_n;
  logic [5:0]  bit_idx, bit_idx_n;
  logic [2:0]  run_len, run_len_n;
  logic        last_bit, last_bit_n;
  logic [14:0] crc, crc_n, crc_rx, crc_rx_n;
  logic [10:0] id_base, id_base_n;
  logic [17:0] id_ext, id_ext_n;
  logic        rtr, rtr_n, ide, ide_n, acked, acked_n;
  logic [3:0]  dlc, dlc_n, idle_cnt, idle_cnt_n;
  logic [63:0] data, data_n;

  logic        frame_valid_n, frame_ide_n, frame_rtr_n, frame_acked_n, error_pulse_n, busy_n;
  logic [28:0] frame_id_n;
  logic [3:0]  frame_dlc_n;
  logic [63:0] frame_data_n;
  logic [2:0]  error_code_n;

  logic        in_stuff, is_stuff, err;
  logic [2:0]  err_code;
  logic [3:0]  nbytes;
  logic [3:0]  dlc_shift;

  assign nbytes    = (dlc > 4'd8) ? 4'd8 : dlc;
  assign dlc_shift = {dlc[2:0], rx_s2};

  always_comb begin
    state_n      = state;
    bit_idx_n    = bit_idx;
    run_len_n    = run_len;
    last_bit_n   = last_bit;
    crc_n        = crc;
    crc_rx_n     = crc_rx;
    id_base_n    = id_base;
    id_ext_n     = id_ext;
    rtr_n        = rtr;
    ide_n        = ide;
    dlc_n        = dlc;
    data_n       = data;
    acked_n      = acked;
    idle_cnt_n   = idle_cnt;
    frame_valid_n = 1'b0;
    frame_id_n    = frame_id;
    frame_ide_n   = frame_ide;
    frame_rtr_n   = frame_rtr;
    frame_dlc_n   = frame_dlc;
    frame_data_n  = frame_data;
    frame_acked_n = frame_acked;
    error_pulse_n = 1'b0;
    error_code_n  = error_code;
    busy_n        = busy;
    err           = 1'b0;
    err_code      = 3'd0;
    in_stuff      = state inside {S_ARB, S_EXT, S_CTRL, S_DATA, S_CRC};
    // A stuff bit may still be due right after the last CRC bit, before the delimiter
    is_stuff      = (in_stuff || state == S_CRC_DEL) && run_len == 3'd5;

    if (sample) begin
      if (is_stuff) begin
        if (rx_s2 == last_bit) begin
          err      = 1'b1;
          err_code = 3'd1;
        end else begin
          last_bit_n = rx_s2;
          run_len_n  = 3'd1;
        end
      end else begin
        if (in_stuff) begin
          if (rx_s2 == last_bit) run_len_n = run_len + 3'd1;
          else begin
            run_len_n  = 3'd1;
            last_bit_n = rx_s2;
          end
        end
        if (state inside {S_ARB, S_EXT, S_CTRL, S_DATA}) crc_n = crc_step(crc, rx_s2);
        case (state)
          S_IDLE_WAIT: begin
            if (!rx_s2) idle_cnt_n = '0;
            else if (idle_cnt == 4'd10) begin
              idle_cnt_n = '0;
              state_n    = S_IDLE;
            end else idle_cnt_n = idle_cnt + 4'd1;
          end
          S_IDLE: begin
            if (!rx_s2) begin
              state_n    = S_ARB;
              busy_n     = 1'b1;
              crc_n      = crc_step('0, 1'b0);
              last_bit_n = 1'b0;
              run_len_n  = 3'd1;
              bit_idx_n  = '0;
              id_base_n  = '0;
              id_ext_n   = '0;
              rtr_n      = 1'b0;
              ide_n      = 1'b0;
              dlc_n      = '0;
              data_n     = '0;
              acked_n    = 1'b0;
            end
          end
          S_ARB: begin
            bit_idx_n = bit_idx + 6'd1;
            if (bit_idx < 6'd11) id_base_n = {id_base[9:0], rx_s2};
            else if (bit_idx == 6'd11) rtr_n = rx_s2;
            else begin
              ide_n     = rx_s2;
              bit_idx_n = '0;
              state_n   = rx_s2 ? S_EXT : S_CTRL;
            end
          end
          S_EXT: begin
            bit_idx_n = bit_idx + 6'd1;
            if (bit_idx < 6'd18) id_ext_n = {id_ext[16:0], rx_s2};
            else if (bit_idx == 6'd18) rtr_n = rx_s2;
            else begin
              bit_idx_n = '0;
              state_n   = S_CTRL;
            end
          end
          S_CTRL: begin
            bit_idx_n = bit_idx + 6'd1;
            if (bit_idx != 6'd0) dlc_n = dlc_shift;
            if (bit_idx == 6'd4) begin
              bit_idx_n = '0;
              state_n   = (rtr || dlc_shift == 4'd0) ? S_CRC : S_DATA;
            end
          end
          S_DATA: begin
            data_n[6'd63 - bit_idx] = rx_s2;
            bit_idx_n = bit_idx + 6'd1;
            if ({1'b0, bit_idx} == 7'({nbytes, 3'b000}) - 7'd1) begin
              bit_idx_n = '0;
              state_n   = S_CRC;
            end
          end
          S_CRC: begin
            crc_rx_n  = {crc_rx[13:0], rx_s2};
            bit_idx_n = bit_idx + 6'd1;
            if (bit_idx == 6'd14) begin
              bit_idx_n = '0;
              state_n   = S_CRC_DEL;
            end
          end
          S_CRC_DEL: begin
            if (crc_rx != crc) begin
              err      = 1'b1;
              err_code = 3'd2;
            end else if (!rx_s2) begin
              err      = 1'b1;
              err_code = 3'd3;
            end else state_n = S_ACK;
          end
          S_ACK: begin
            acked_n = !rx_s2;
            state_n = S_ACK_DEL;
          end
          S_ACK_DEL: begin
            if (!rx_s2) begin
              err      = 1'b1;
              err_code = 3'd3;
            end else begin
              bit_idx_n = '0;
              state_n   = S_EOF;
            end
          end
          S_EOF: begin
            if (!rx_s2) begin
              err      = 1'b1;
              err_code = 3'd3;
            end else if (bit_idx == 6'd6) begin
              frame_valid_n = 1'b1;
              busy_n        = 1'b0;
              frame_id_n    = ide ? {id_base, id_ext} : {18'b0, id_base};
              frame_ide_n   = ide;
              frame_rtr_n   = rtr;
              frame_dlc_n   = dlc;
              frame_data_n  = data;
              frame_acked_n = acked;
              state_n       = S_IDLE;
            end else bit_idx_n = bit_idx + 6'd1;
          end
          default: state_n = S_IDLE_WAIT;
        endcase
      end
    end

    if (err) begin
      error_pulse_n = 1'b1;
      error_code_n  = err_code;
      busy_n        = 1'b0;
      idle_cnt_n    = '0;
      state_n       = S_IDLE_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE_WAIT;
      bit_idx     <= '0;
      run_len     <= '0;
      last_bit    <= 1'b1;
      crc         <= '0;
      crc_rx      <= '0;
      id_base     <= '0;
      id_ext      <= '0;
      rtr         <= 1'b0;
      ide         <= 1'b0;
      dlc         <= '0;
      data        <= '0;
      acked       <= 1'b0;
      idle_cnt    <= '0;
      frame_valid <= 1'b0;
      frame_id    <= '0;
      frame_ide   <= 1'b0;
      frame_rtr   <= 1'b0;
      frame_dlc   <= '0;
      frame_data  <= '0;
      frame_acked <= 1'b0;
      error_pulse <= 1'b0;
      error_code  <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      bit_idx     <= bit_idx_n;
      run_len     <= run_len_n;
      last_bit    <= last_bit_n;
      crc         <= crc_n;
      crc_rx      <= crc_rx_n;
      id_base     <= id_base_n;
      id_ext      <= id_ext_n;
      rtr         <= rtr_n;
      ide         <= ide_n;
      dlc         <= dlc_n;
      data        <= data_n;
      acked       <= acked_n;
      idle_cnt    <= idle_cnt_n;
      frame_valid <= frame_valid_n;
      frame_id    <= frame_id_n;
      frame_ide   <= frame_ide_n;
      frame_rtr   <= frame_rtr_n;
      frame_dlc   <= frame_dlc_n;
      frame_data  <= frame_data_n;
      frame_acked <= frame_acked_n;
      error_pulse <= error_pulse_n;
      error_code  <= error_code_n;
      busy        <= busy_n;
    end
  end

endmodule
